// File: rtl/std_nbdcache_data_ctrl_pkg.sv
// Shared types and width helpers for the nbdcache data-array controller.
package std_nbdcache_data_pkg;

  typedef enum logic {INIT, RUN} state_e;

  // Width of a way index; a single way still needs one bit.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Width of the credit counter, which spans 0..Latency+1.
  function automatic int cred_w(input int lat);
    return $clog2(lat + 2);
  endfunction

endpackage

// File: rtl/std_nbdcache_data_ctrl_if.sv
// Generic valid/ready data stream used between the capture stage and the
// response FIFO.
interface std_nbdcache_data_ctrl_if #(
  parameter int Width = 32
);
  logic             valid;
  logic             ready;
  logic [Width-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/std_nbdcache_data_rsp_fifo.sv
// Small circular FIFO holding captured read data until the consumer takes it.
module std_nbdcache_data_rsp_fifo
  import std_nbdcache_data_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  std_nbdcache_data_ctrl_if.slave   in_if,
  std_nbdcache_data_ctrl_if.master  out_if
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count;
  logic             push, pop;

  assign in_if.ready  = (count != CntW'(Depth));
  assign out_if.valid = (count != '0);
  assign out_if.data  = mem[rd_ptr];
  assign push = in_if.valid && in_if.ready;
  assign pop  = out_if.valid && out_if.ready;

  // Pointer and occupancy bookkeeping; pointers wrap at Depth (not a power of two).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= in_if.data;
  end

endmodule

// File: rtl/std_nbdcache_data_ctrl.sv
// Data-array controller for the non-blocking dcache: steers requests to one
// way, pipelines read returns into a credit-bounded response FIFO.
// Optional power-on zero sweep of all ways: STD_NBDCACHE_DATA_INIT_EN.
module std_nbdcache_data_ctrl
  import std_nbdcache_data_pkg::*;
#(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 128,
  parameter int ByteWidth = 8,
  parameter int WAY_COUNT = 1,
  parameter int Latency   = 1,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth   = DataWidth / ByteWidth,
  localparam int WayWidth  = way_w(WAY_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [WayWidth-1:0]  req_way_i,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 init_done_o,
  output logic [WAY_COUNT-1:0] sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i [WAY_COUNT]
);
  localparam int CredWidth = cred_w(Latency);
  localparam logic [CredWidth-1:0] CredFull = CredWidth'(Latency + 1);

  logic                 done_q;
  logic                 accept, rd_accept, rsp_pop;
  logic [CredWidth-1:0] credits;
  logic [Latency:1]     vld_pipe;
  logic [Latency:1][WayWidth-1:0] way_pipe;
  logic [DataWidth-1:0] cap_data;

`ifdef STD_NBDCACHE_DATA_INIT_EN
  state_e               state;
  logic [AddrWidth-1:0] sweep_addr;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  // Zero-fill every way once, then open up for traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= INIT;
      sweep_addr <= '0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (sweep_addr == LastAddr) begin
            state  <= RUN;
            done_q <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
`else
  // No sweep: ready from the first clock edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) done_q <= 1'b0;
    else         done_q <= 1'b1;
  end
`endif

  assign init_done_o = done_q;
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;
  // A pop frees a credit in the same cycle, so a new read may slip in then.
  assign req_ready_o = done_q && ((credits != CredFull) || rsp_pop);
  assign accept      = req_valid_i && req_ready_o;
  assign rd_accept   = accept && !req_we_i;

  // Way-array request: one-hot way on accept, or the whole array during sweep.
  always_comb begin
    sram_req_o   = '0;
    for (int w = 0; w < WAY_COUNT; w++)
      if (accept && (req_way_i == WayWidth'(w))) sram_req_o[w] = 1'b1;
    sram_we_o    = req_we_i;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o    = req_be_i;
`ifdef STD_NBDCACHE_DATA_INIT_EN
    if (state == INIT) begin
      sram_req_o   = '1;
      sram_we_o    = 1'b1;
      sram_addr_o  = sweep_addr;
      sram_wdata_o = '0;
      sram_be_o    = '1;
    end
`endif
  end

  // Read valid shift register, aligned with the SRAM read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_pipe <= '0;
    else begin
      for (int s = Latency; s > 1; s--) vld_pipe[s] <= vld_pipe[s-1];
      vld_pipe[1] <= rd_accept;
    end
  end

  // Way index travels alongside the valid; qualified by vld_pipe only.
  always_ff @(posedge clk_i) begin
    for (int s = Latency; s > 1; s--) way_pipe[s] <= way_pipe[s-1];
    way_pipe[1] <= req_way_i;
  end

  // Select the returning way; an out-of-range way yields zero.
  always_comb begin
    cap_data = '0;
    for (int w = 0; w < WAY_COUNT; w++)
      if (way_pipe[Latency] == WayWidth'(w)) cap_data = sram_rdata_i[w];
  end

  // Reads in flight plus buffered responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                   credits <= '0;
    else if (rd_accept && !rsp_pop) credits <= credits + 1'b1;
    else if (!rd_accept && rsp_pop) credits <= credits - 1'b1;
  end

  std_nbdcache_data_ctrl_if #(.Width(DataWidth)) cap_if ();
  std_nbdcache_data_ctrl_if #(.Width(DataWidth)) out_if ();

  // Credits guarantee a free slot whenever a capture lands.
  assign cap_if.valid = vld_pipe[Latency] && cap_if.ready;
  assign cap_if.data  = cap_data;
  assign out_if.ready = rsp_ready_i;
  assign rsp_valid_o  = out_if.valid;
  assign rsp_rdata_o  = out_if.data;

  std_nbdcache_data_rsp_fifo #(
    .Depth (Latency + 1),
    .Width (DataWidth)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_if  (cap_if),
    .out_if (out_if)
  );

endmodule

// File: tb/tb_std_nbdcache_data_ctrl.sv
// Directed bench: 2-way main instance with a behavioural SRAM, plus a 3-way
// instance for the out-of-range way case.
module tb_std_nbdcache_data_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // main instance: 2 ways, 16 words, 32-bit data, latency 1
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, init_done, sram_we;
  logic [0:0]  req_way;
  logic [3:0]  req_addr, req_be, sram_addr, sram_be;
  logic [31:0] req_wdata, rsp_rdata, sram_wdata;
  logic [1:0]  sram_req;
  logic [31:0] sram_rdata [2];
  logic [31:0] mem [2][16];

  std_nbdcache_data_ctrl_if #(.Width(32)) rsp_bus ();
  assign rsp_bus.valid = rsp_valid;
  assign rsp_bus.data  = rsp_rdata;
  assign rsp_bus.ready = rsp_ready;

  std_nbdcache_data_ctrl #(
    .NumWords(16), .DataWidth(32), .ByteWidth(8), .WAY_COUNT(2), .Latency(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_way_i(req_way),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_bus.ready), .rsp_rdata_o(rsp_rdata),
    .init_done_o(init_done),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // behavioural byte-enabled SRAM, one-cycle read latency
  always @(posedge clk) begin
    for (int w = 0; w < 2; w++)
      if (sram_req[w]) begin
        if (sram_we) begin
          for (int b = 0; b < 4; b++)
            if (sram_be[b]) mem[w][sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end else sram_rdata[w] <= mem[w][sram_addr];
      end
  end

  // 3-way instance with constant per-way read data
  logic        req_valid3, req_ready3, req_we3, rsp_valid3, rsp_ready3, init_done3, sram_we3;
  logic [1:0]  req_way3;
  logic [3:0]  req_addr3, sram_addr3, sram_be3;
  logic [31:0] rsp_rdata3, sram_wdata3;
  logic [2:0]  sram_req3;
  logic [31:0] sram_rdata3 [3];

  std_nbdcache_data_ctrl #(
    .NumWords(16), .DataWidth(32), .ByteWidth(8), .WAY_COUNT(3), .Latency(1)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_way_i(req_way3),
    .req_we_i(req_we3), .req_addr_i(req_addr3), .req_wdata_i(32'h0), .req_be_i(4'hF),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_rdata_o(rsp_rdata3),
    .init_done_o(init_done3),
    .sram_req_o(sram_req3), .sram_we_o(sram_we3), .sram_addr_o(sram_addr3),
    .sram_wdata_o(sram_wdata3), .sram_be_o(sram_be3), .sram_rdata_i(sram_rdata3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic we, input logic [0:0] way,
                     input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] be);
    req_valid = v; req_we = we; req_way = way; req_addr = addr; req_wdata = wd; req_be = be;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_init;
    int n = 0;
    while (!(init_done && init_done3) && n < 40) begin
      tick(); #1; n++;
    end
    chk("init_wait", {62'd0, init_done, init_done3}, 64'h3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    rsp_ready = 1'b1;
    req_valid3 = 0; req_we3 = 0; req_way3 = 0; req_addr3 = 0; rsp_ready3 = 1'b1;
    sram_rdata3[0] = 32'h0101_0101;
    sram_rdata3[1] = 32'h0202_0202;
    sram_rdata3[2] = 32'h5A5A_5A5A;

    // reset state
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_sram_req", sram_req, 0);
    chk("rst_req_ready3", req_ready3, 0);

    tick(); rst_n = 1'b1; #1;
`ifdef STD_NBDCACHE_DATA_INIT_EN
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin tick(); #1; end
      chk("init_sram_req", sram_req, 2'b11);
      chk("init_addr", sram_addr, k);
      chk("init_wdata", sram_wdata, 0);
      chk("init_we_be", {sram_we, sram_be}, 5'h1F);
      chk("init_ready", {init_done, req_ready}, 0);
    end
    tick(); #1;
    chk("init_done", init_done, 1);
    chk("init_sram_req_off", sram_req, 0);
`else
    tick(); #1;
    chk("run_init_done", init_done, 1);
    chk("run_req_ready", req_ready, 1);
`endif

    // write way1 addr5, then read it back
    tick(); drv(1, 1, 1, 5, 32'hDEADBEEF, 4'hF); #1;
    chk("wr_sram_req", sram_req, 2'b10);
    chk("wr_sram_addr", sram_addr, 5);
    chk("wr_ready", req_ready, 1);
    tick(); drv(1, 0, 1, 5, 0, 0); #1;
    chk("rd_sram_req", sram_req, 2'b10);
    tick(); drv(0, 0, 0, 0, 0, 0); #1;
    chk("rd_lat_not_yet", rsp_valid, 0);
    chk("idle_sram_req", sram_req, 0);
    tick(); #1;
    chk("rd_lat_valid", rsp_valid, 1);
    chk("rd_lat_data", rsp_rdata, 32'hDEADBEEF);
    tick(); #1;
    chk("rd_popped", rsp_valid, 0);

    // partial byte-enable write
    tick(); drv(1, 1, 0, 3, 32'hAAAAAAAA, 4'hF);
    tick(); drv(1, 1, 0, 3, 32'h11223344, 4'h3);
    tick(); drv(1, 1, 1, 2, 32'h12345678, 4'hF);
    tick(); drv(1, 0, 0, 3, 0, 0);
    tick(); drv(0, 0, 0, 0, 0, 0);
    tick(); #1;
    chk("be_data", rsp_rdata, 32'hAAAA3344);
    chk("be_valid", rsp_valid, 1);

    // back-pressure: two reads fill the credits, third waits for a pop
    tick(); #1;
    rsp_ready = 1'b0;
    tick(); drv(1, 0, 0, 3, 0, 0); #1;
    chk("bp_ready1", req_ready, 1);
    tick(); drv(1, 0, 1, 5, 0, 0); #1;
    chk("bp_ready2", req_ready, 1);
    tick(); drv(1, 0, 1, 2, 0, 0); #1;
    chk("bp_ready_full", req_ready, 0);
    chk("bp_sram_req_blocked", sram_req, 0);
    tick(); #1;
    chk("bp_still_full", req_ready, 0);
    chk("bp_head", rsp_rdata, 32'hAAAA3344);
    rsp_ready = 1'b1; #1;
    chk("bp_ready_on_pop", req_ready, 1);
    chk("bp_third_sram_req", sram_req, 2'b10);
    tick(); drv(0, 0, 0, 0, 0, 0); #1;
    chk("bp_second", rsp_rdata, 32'hDEADBEEF);
    tick(); #1;
    chk("bp_third", rsp_rdata, 32'h12345678);
    tick(); #1;
    chk("bp_drained", rsp_valid, 0);

    // reset with reads pending
    rsp_ready = 1'b0;
    tick(); drv(1, 0, 0, 3, 0, 0);
    tick(); drv(1, 0, 1, 5, 0, 0);
    tick(); drv(0, 0, 0, 0, 0, 0); rst_n = 1'b0; #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    tick(); rst_n = 1'b1;
    wait_init();
    tick(); #1;
    chk("post_rst_rsp_valid", rsp_valid, 0);
    // credits must be back at zero: two more reads fit, then full
    tick(); drv(1, 1, 0, 3, 32'h0BADF00D, 4'hF);
    tick(); drv(1, 0, 0, 3, 0, 0); #1;
    chk("post_rst_ready1", req_ready, 1);
    tick(); drv(1, 0, 0, 3, 0, 0); #1;
    chk("post_rst_ready2", req_ready, 1);
    tick(); #1;
    chk("post_rst_full", req_ready, 0);
    chk("post_rst_data", rsp_rdata, 32'h0BADF00D);
    drv(0, 0, 0, 0, 0, 0); rsp_ready = 1'b1;
    tick(); #1;
    chk("post_rst_second", {rsp_valid, rsp_rdata}, {1'b1, 32'h0BADF00D});
    tick(); #1;
    chk("post_rst_drained", rsp_valid, 0);

    // out-of-range way on the 3-way instance
    tick(); req_valid3 = 1; req_we3 = 0; req_way3 = 2'd3; #1;
    chk("oor_rd_sram_req", sram_req3, 0);
    chk("oor_ready", req_ready3, 1);
    tick(); req_way3 = 2'd2; #1;
    chk("way2_sram_req", sram_req3, 3'b100);
    tick(); req_we3 = 1; req_way3 = 2'd3; #1;
    chk("oor_wr_sram_req", sram_req3, 0);
    chk("oor_rd_data", {rsp_valid3, rsp_rdata3}, {1'b1, 32'h0});
    tick(); req_valid3 = 0; req_we3 = 0; #1;
    chk("way2_data", {rsp_valid3, rsp_rdata3}, {1'b1, 32'h5A5A5A5A});
    tick(); #1;
    chk("oor_no_extra", rsp_valid3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
